// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IF stage: PC, one-outstanding imem requests, IF/ID register with skid
//
// Ports:
//   clk, rst_n                  clock (rising edge), synchronous active-low reset
//   fetch_en                    0 stops new requests; outstanding work drains normally
//   redirect_valid, redirect_pc taken branch/jump, highest priority
//   imem_req/imem_addr/imem_gnt request handshake, address = pc
//   imem_rvalid/imem_rdata      in-order response, at least one cycle after grant
//   if_valid/if_instr/if_pc     IF/ID register towards decode
//   id_ready                    decode consumes IF/ID when if_valid && id_ready
//   perf_fetched, perf_stall    only when IF_PERF_CNT_EN is defined
//
// Optional feature macro: IF_PERF_CNT_EN (performance counters).

module instruction_fetch #(
    parameter int                INSTR_W  = 20,
    parameter int                ADDR_W   = 11,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               id_ready
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall
`endif
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  pc, pc_n;
    logic [ADDR_W-1:0]  req_pc, req_pc_n;
    logic               drop, drop_n;
    logic [INSTR_W-1:0] skid_instr, skid_instr_n;
    logic [ADDR_W-1:0]  skid_pc, skid_pc_n;
    logic               if_valid_n;
    logic [INSTR_W-1:0] if_instr_n;
    logic [ADDR_W-1:0]  if_pc_n;
    logic               load;
    logic               grant;

    always_comb begin
        // Request is masked during reset and on redirect so a grant can never
        // race with the PC being replaced.
        imem_req     = rst_n && (state == S_ISSUE) && fetch_en && !redirect_valid;
        imem_addr    = pc;
        grant        = imem_req && imem_gnt;

        state_n      = state;
        pc_n         = pc;
        req_pc_n     = req_pc;
        drop_n       = drop;
        skid_instr_n = skid_instr;
        skid_pc_n    = skid_pc;
        if_valid_n   = if_valid && !id_ready;
        if_instr_n   = if_instr;
        if_pc_n      = if_pc;
        load         = 1'b0;

        if (redirect_valid) begin
            pc_n       = redirect_pc;
            if_valid_n = 1'b0;
            // A response still in flight belongs to the old path: wait for it
            // and throw it away. If it lands this very cycle it is simply ignored.
            if (state == S_WAIT && !imem_rvalid) begin
                state_n = S_WAIT;
                drop_n  = 1'b1;
            end else begin
                state_n = S_ISSUE;
                drop_n  = 1'b0;
            end
        end else begin
            case (state)
                S_ISSUE: begin
                    if (grant) begin
                        state_n  = S_WAIT;
                        pc_n     = pc + 1'b1;
                        req_pc_n = pc;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_n = S_ISSUE;
                        if (drop) begin
                            drop_n = 1'b0;
                        end else if (!if_valid || id_ready) begin
                            load       = 1'b1;
                            if_instr_n = imem_rdata;
                            if_pc_n    = req_pc;
                        end else begin
                            skid_instr_n = imem_rdata;
                            skid_pc_n    = req_pc;
                            state_n      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    // if_valid is always set while the skid is full.
                    if (id_ready) begin
                        load       = 1'b1;
                        if_instr_n = skid_instr;
                        if_pc_n    = skid_pc;
                        state_n    = S_ISSUE;
                    end
                end
                default: state_n = S_ISSUE;
            endcase
            if (load) begin
                if_valid_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_ISSUE;
            pc         <= RESET_PC;
            req_pc     <= '0;
            drop       <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            req_pc     <= req_pc_n;
            drop       <= drop_n;
            skid_instr <= skid_instr_n;
            skid_pc    <= skid_pc_n;
            if_valid   <= if_valid_n;
            if_instr   <= if_instr_n;
            if_pc      <= if_pc_n;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (load) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (if_valid && !id_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch against a stream-level model

module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n, fetch_en, redirect_valid, imem_gnt, imem_rvalid, id_ready;
    logic [10:0] redirect_pc;
    logic [19:0] imem_rdata;
    logic        imem_req, if_valid;
    logic [10:0] imem_addr, if_pc;
    logic [19:0] if_instr;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    always #5 clk = ~clk;

    instruction_fetch #(.INSTR_W(20), .ADDR_W(11), .RESET_PC(11'd0)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready)
`ifdef IF_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
    );

    int nvec = 0;
    int nmis = 0;

    // stimulus knobs
    logic        k_rstn = 1'b0, k_fetch_en = 1'b1, k_ready = 1'b1;
    logic        k_redirect = 1'b0, k_redir_on_rv = 1'b0;
    logic [10:0] k_redirect_pc = '0;
    int          k_gnt_prob = 100, k_lat_min = 1, k_lat_max = 1;

    // model: instruction memory, outstanding response, expected streams
    logic [19:0] mem [0:2047];
    logic        mem_pend = 1'b0;
    logic [10:0] mem_addr = '0;
    int          mem_cnt = 0;
    logic [10:0] exp_pc = '0;       // next pc decode must receive
    logic [10:0] fetch_pc = '0;     // next pc the fetcher must request
    logic        prev_stall = 1'b0, prev_redirect = 1'b0, prev_rst = 1'b0;
    logic [10:0] prev_pc = '0;
    logic [19:0] prev_instr = '0;
    int          cyc = 0, deliv_cnt = 0, last_cyc = 0, ngrant = 0;
    logic [10:0] last_pc = '0;
    logic [19:0] last_instr = '0;
    logic        grant_flag = 1'b0, did_redirect = 1'b0;
    logic [10:0] grant_addr = '0;
    logic        s_if_valid = 1'b0, s_imem_req = 1'b0;
    logic [10:0] s_if_pc = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic hs, gr;
        @(negedge clk);
        rst_n       = k_rstn;
        fetch_en    = k_fetch_en;
        id_ready    = k_ready;
        imem_rvalid = 1'b0;
        imem_rdata  = 20'($urandom);
        if (mem_pend && mem_cnt == 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem[mem_addr];
        end
        redirect_valid = k_redirect || (k_redir_on_rv && imem_rvalid);
        redirect_pc    = k_redirect_pc;
        imem_gnt       = ($urandom_range(99) < k_gnt_prob);
        #1;
        s_if_valid = if_valid;
        s_if_pc    = if_pc;
        s_imem_req = imem_req;
        grant_flag = 1'b0;
        did_redirect = 1'b0;
        if (!rst_n) begin
            chk("req_in_reset", 32'(imem_req), 32'd0);
            if (prev_rst) begin
                chk("rst_if_valid", 32'(if_valid), 32'd0);
                chk("rst_if_pc", 32'(if_pc), 32'd0);
                chk("rst_if_instr", 32'(if_instr), 32'd0);
            end
            mem_pend = 1'b0; exp_pc = '0; fetch_pc = '0;
            prev_stall = 1'b0; prev_redirect = 1'b0; prev_rst = 1'b1;
            cyc = 0; ngrant = 0;
        end else begin
            chk("req_gate", 32'(imem_req && !(fetch_en && !redirect_valid && !mem_pend)), 32'd0);
            if (imem_req) chk("req_addr", 32'(imem_addr), 32'(fetch_pc));
            if (prev_redirect) chk("valid_after_redirect", 32'(if_valid), 32'd0);
            if (prev_stall) begin
                chk("stall_valid", 32'(if_valid), 32'd1);
                chk("stall_pc", 32'(if_pc), 32'(prev_pc));
                chk("stall_instr", 32'(if_instr), 32'(prev_instr));
            end
            hs = if_valid && id_ready && !redirect_valid;
            if (hs) begin
                chk("deliver_pc", 32'(if_pc), 32'(exp_pc));
                chk("deliver_instr", 32'(if_instr), 32'(mem[exp_pc]));
                deliv_cnt++;
                last_pc = if_pc; last_instr = if_instr; last_cyc = cyc;
                exp_pc = exp_pc + 11'd1;
            end
            if (imem_rvalid) mem_pend = 1'b0;
            else if (mem_pend) mem_cnt--;
            gr = imem_req && imem_gnt;
            if (gr) begin
                mem_pend = 1'b1; mem_addr = imem_addr;
                mem_cnt = $urandom_range(k_lat_max, k_lat_min);
                fetch_pc = fetch_pc + 11'd1;
                grant_flag = 1'b1; grant_addr = imem_addr; ngrant++;
            end
            if (redirect_valid) begin
                exp_pc = redirect_pc; fetch_pc = redirect_pc; did_redirect = 1'b1;
            end
            prev_stall    = if_valid && !id_ready && !redirect_valid;
            prev_pc       = if_pc;
            prev_instr    = if_instr;
            prev_redirect = redirect_valid;
            prev_rst      = 1'b0;
            cyc++;
        end
    endtask

    task automatic wait_deliv(input int budget);
        int start = deliv_cnt;
        int n = 0;
        while (deliv_cnt == start && n < budget) begin
            step();
            n++;
        end
        chk("deliver_timeout", 32'(deliv_cnt != start), 32'd1);
    endtask

    task automatic do_reset();
        k_rstn = 1'b0;
        step();
        step();
        k_rstn = 1'b1;
    endtask

    initial begin
        int c0;
        for (int i = 0; i < 2048; i++) mem[i] = 20'($urandom);
        mem[0] = 20'h02D00;

        // basic streaming, 1-cycle memory: one instruction every 2 cycles
        do_reset();
        wait_deliv(20);
        chk("first_pc", 32'(last_pc), 32'd0);
        chk("first_instr", 32'(last_instr), 32'h02D00);
        chk("first_cyc", 32'(last_cyc), 32'd2);
        wait_deliv(20);
        chk("second_cyc", 32'(last_cyc), 32'd4);
        wait_deliv(20);
        chk("third_pc", 32'(last_pc), 32'd2);
        chk("third_cyc", 32'(last_cyc), 32'd6);

        // backpressure: skid fills, request stops, nothing lost on release
        do_reset();
        k_ready = 1'b0;
        for (int i = 0; i < 20 && !s_if_valid; i++) step();
        for (int i = 0; i < 6; i++) step();
        chk("hold_req", 32'(s_imem_req), 32'd0);
        chk("hold_pc", 32'(s_if_pc), 32'd0);
        k_ready = 1'b1;
        wait_deliv(20);
        chk("release_pc0", 32'(last_pc), 32'd0);
        c0 = last_cyc;
        wait_deliv(20);
        chk("release_pc1", 32'(last_pc), 32'd1);
        chk("release_back2back", 32'(last_cyc), 32'(c0 + 1));
        wait_deliv(20);
        chk("release_pc2", 32'(last_pc), 32'd2);

        // redirect with a 3-cycle response outstanding for pc 5
        do_reset();
        k_lat_min = 3; k_lat_max = 3;
        for (int i = 0; i < 200 && !(grant_flag && grant_addr == 11'd5); i++) step();
        chk("saw_grant5", 32'(grant_flag && grant_addr == 11'd5), 32'd1);
        k_redirect = 1'b1; k_redirect_pc = 11'h0C3;
        step();
        k_redirect = 1'b0;
        step();
        chk("redir_clear", 32'(s_if_valid), 32'd0);
        wait_deliv(40);
        chk("redir_pc", 32'(last_pc), 32'h0C3);

        // redirect in the same cycle as a response
        k_lat_min = 2; k_lat_max = 2;
        k_redirect_pc = 11'h155; k_redir_on_rv = 1'b1;
        for (int i = 0; i < 50 && !did_redirect; i++) step();
        k_redir_on_rv = 1'b0;
        chk("rv_redirect_seen", 32'(did_redirect), 32'd1);
        wait_deliv(40);
        chk("rv_redir_pc", 32'(last_pc), 32'h155);

        // redirect while the skid is full
        k_lat_min = 1; k_lat_max = 1; k_ready = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("skid_full_req", 32'(s_imem_req), 32'd0);
        k_redirect = 1'b1; k_redirect_pc = 11'h2A0;
        step();
        k_redirect = 1'b0; k_ready = 1'b1;
        wait_deliv(40);
        chk("skid_redir_pc", 32'(last_pc), 32'h2A0);

        // pc wrap
        k_redirect = 1'b1; k_redirect_pc = 11'h7FF;
        step();
        k_redirect = 1'b0;
        wait_deliv(40);
        chk("wrap_7ff", 32'(last_pc), 32'h7FF);
        wait_deliv(40);
        chk("wrap_000", 32'(last_pc), 32'h000);
        wait_deliv(40);
        chk("wrap_001", 32'(last_pc), 32'h001);

        // randomized traffic checked by the model on every cycle
        k_lat_min = 1; k_lat_max = 4;
        for (int i = 0; i < 4000; i++) begin
            k_rstn        = ($urandom_range(999) != 0);
            k_fetch_en    = ($urandom_range(9) != 0);
            k_ready       = ($urandom_range(9) < 7);
            k_gnt_prob    = 70;
            k_redirect    = ($urandom_range(99) < 3);
            k_redirect_pc = 11'($urandom);
            step();
        end
        k_rstn = 1'b1; k_fetch_en = 1'b1; k_ready = 1'b1; k_redirect = 1'b0; k_gnt_prob = 100;
        wait_deliv(40);

`ifdef IF_PERF_CNT_EN
        begin
            int nst = 0;
            k_lat_min = 1; k_lat_max = 1;
            do_reset();
            for (int i = 0; i < 100; i++) begin
                k_fetch_en = (ngrant < 10);
                k_ready    = !(nst < 4 && ngrant >= 3);
                step();
                if (!k_ready && s_if_valid) nst++;
            end
            chk("perf_fetched", perf_fetched, 32'd10);
            chk("perf_stall", perf_stall, 32'd4);
            do_reset();
            chk("perf_fetched_rst", perf_fetched, 32'd0);
            chk("perf_stall_rst", perf_stall, 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
